afe2256_channel_aligner: RTL and testbench
==========================================

Name: afe2256_channel_aligner

Overview:
- Multi-channel pixel deskew and merge stage. Sits after the per-channel LVDS receive path, once each channel's pixel stream is in the clk_sys domain.
- Buffers each channel in a small FIFO and aligns all enabled channels on a common line_start.
- Emits one merged word (all channels, same pixel index) per valid/ready handshake.
- Detects skew timeout, line misalignment and FIFO overflow.

Parameters:
- NUM_CHANNELS, 14: number of pixel channels (1-16).
- PIXEL_WIDTH, 12: bits per pixel.
- FIFO_DEPTH, 16: entries per channel FIFO; power of two, >=4.
- SKEW_MAX, 8: max cycles allowed between the first and last enabled channel presenting line_start.

Ports:
- clk_sys  in  1  system clock; all logic is in this domain.
- rst  in  1  asynchronous active-high reset.
- ch_enable  in  NUM_CHANNELS  channel participation mask; latched on leaving IDLE.
- resync  in  1  single-cycle pulse: flush FIFOs, return to IDLE.
- clear_errors  in  1  single-cycle pulse: clears sticky error flags.
- in_data  in  NUM_CHANNELS x PIXEL_WIDTH  per-channel pixel.
- in_valid  in  NUM_CHANNELS  per-channel pixel strobe.
- in_line_start  in  NUM_CHANNELS  first pixel of a line; qualified by in_valid.
- in_frame_start  in  NUM_CHANNELS  first pixel of a frame; qualified by in_valid, implies line_start.
- out_data  out  NUM_CHANNELS x PIXEL_WIDTH  merged pixels; disabled channels drive 0.
- out_valid  out  1  merged word available.
- out_ready  in  1  downstream accepts.
- out_line_start  out  1  merged word is first of a line.
- out_frame_start  out  1  merged word is first of a frame.
- aligned  out  1  high while in STREAM.
- skew_error  out  1  sticky.
- misalign_error  out  1  sticky.
- overflow  out  NUM_CHANNELS  sticky, per channel.

Behaviour:
- Reset: state=IDLE, all FIFOs empty, armed=0, latched mask=0, skew counter=0. All outputs 0.
- FIFO entry layout: {frame_start, line_start, data}, PIXEL_WIDTH+2 bits. Write happens on the clock edge; the entry is visible at the head the next cycle.
- IDLE:
  - No FIFO writes.
  - If ch_enable != 0: latch the mask, go to HUNT next cycle.
  - If ch_enable == 0: stay in IDLE.
- HUNT:
  - An enabled, unarmed channel discards pixels until in_valid & in_line_start.
  - That pixel is written and the channel becomes armed.
  - An armed channel writes every valid pixel.
  - The skew counter starts at 0 on the cycle the first channel arms, then increments each cycle.
  - All enabled channels armed (including arming in the same cycle): go to STREAM next cycle, counter cleared.
  - Counter reaches SKEW_MAX with any channel still unarmed: set skew_error, flush all FIFOs, clear armed, stay in HUNT.
- STREAM:
  - Enabled channels write every valid pixel.
  - out_valid=1 when every enabled FIFO is non-empty and all head line_start flags are equal.
  - out_data, out_line_start and out_frame_start come from the heads. Flags are taken from the lowest enabled channel.
  - Pop all enabled FIFOs on out_valid & out_ready.
  - out_valid must not drop without a handshake unless an error or resync flush occurs.
  - All enabled heads present and line_start flags disagree: set misalign_error, flush, go to HUNT, out_valid=0 that cycle.
- Latency: the first out_valid is asserted the cycle after the last channel's line_start pixel is sampled. Steady-state throughput is 1 word/cycle.
- Overflow:
  - A write to a full FIFO (HUNT or STREAM) drops the pixel and sets overflow[ch].
  - It then flushes all FIFOs and goes to HUNT.
  - A pop and a write in the same cycle on a full FIFO is not an overflow.
- Flush: pointers and armed flags clear on the next edge. The input pixel presented that cycle is discarded.
- Simultaneous events:
  - resync has top priority: flush and go to IDLE; errors are not set by resync.
  - Overflow and timeout/misalign in the same cycle set both flags.
  - clear_errors in the same cycle as a new error: the error wins (flag stays 1).
- ch_enable changes outside IDLE are ignored until resync.
- Disabled channels: inputs ignored, FIFOs held empty, overflow never set.

Test Plan:
- Aligned start: NUM_CHANNELS=4, all enabled, line_start on all at cycle 10, pixels 0x100+n, out_ready=1. Expect out_valid at cycle 11, out_line_start=1 on the first word, then 1 word/cycle with values 0x100.. in every lane.
- Skew within limit: ch3 line_start 5 cycles after ch0, SKEW_MAX=8. Expect STREAM entry with no skew_error, and the first merged word holds each channel's line_start pixel.
- Skew timeout: ch2 never asserts line_start. Expect skew_error=1 exactly SKEW_MAX cycles after ch0 arms, FIFOs flushed, aligned=0; clear_errors then returns skew_error to 0.
- Backpressure overflow: FIFO_DEPTH=16, out_ready=0, 17 valid pixels per channel. Expect overflow=all enabled bits, state HUNT, out_valid=0 after the flush.
- Misalign plus mask: ch_enable=4'b1010. Inject an extra pixel on ch1 mid-line so the next line_start heads disagree. Expect misalign_error=1 and a return to HUNT. Lanes 0 and 2 read 0 throughout; overflow[0] stays 0.
- Reset mid-stream: assert rst during STREAM. Expect all outputs 0 immediately (asynchronous), IDLE after release, and a clean re-lock on the next line_start.

Source files
------------

// File: rtl/afe2256_channel_aligner.sv
// ---------------------------------------------------------------------------
// afe2256_channel_aligner
//
// Multi-channel pixel deskew and merge stage. Each channel's pixel stream
// (already in the clk_sys domain) is buffered in a small FIFO. All enabled
// channels are aligned on a common line_start. One merged word holding the
// same pixel index from every channel is emitted per valid/ready handshake.
// Skew timeout, line misalignment and FIFO overflow are detected and
// reported through sticky flags.
//
// Ports
//   clk_sys          system clock, all logic in this domain
//   rst              asynchronous active-high reset
//   ch_enable        channel participation mask, latched when leaving IDLE
//   resync           pulse: flush all FIFOs and return to IDLE
//   clear_errors     pulse: clear sticky error flags
//   in_data          per-channel pixels, lane c at [c*PIXEL_WIDTH +: PIXEL_WIDTH]
//   in_valid         per-channel pixel strobe
//   in_line_start    per-channel first pixel of a line (qualified by in_valid)
//   in_frame_start   per-channel first pixel of a frame (implies line_start)
//   out_data         merged pixels; disabled lanes drive 0
//   out_valid        merged word available
//   out_ready        downstream accepts the merged word
//   out_line_start   merged word is the first of a line
//   out_frame_start  merged word is the first of a frame
//   aligned          high while streaming
//   skew_error       sticky: channels did not all present line_start in time
//   misalign_error   sticky: head line_start flags disagreed while streaming
//   overflow         sticky, per channel: write attempted into a full FIFO
// ---------------------------------------------------------------------------
module afe2256_channel_aligner #(
    parameter int NUM_CHANNELS = 14,
    parameter int PIXEL_WIDTH  = 12,
    parameter int FIFO_DEPTH   = 16,
    parameter int SKEW_MAX     = 8
) (
    input  logic                                clk_sys,
    input  logic                                rst,
    input  logic [NUM_CHANNELS-1:0]             ch_enable,
    input  logic                                resync,
    input  logic                                clear_errors,
    input  logic [NUM_CHANNELS*PIXEL_WIDTH-1:0] in_data,
    input  logic [NUM_CHANNELS-1:0]             in_valid,
    input  logic [NUM_CHANNELS-1:0]             in_line_start,
    input  logic [NUM_CHANNELS-1:0]             in_frame_start,
    output logic [NUM_CHANNELS*PIXEL_WIDTH-1:0] out_data,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic                                out_line_start,
    output logic                                out_frame_start,
    output logic                                aligned,
    output logic                                skew_error,
    output logic                                misalign_error,
    output logic [NUM_CHANNELS-1:0]             overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = PIXEL_WIDTH + 2;       // {frame_start, line_start, data}
    localparam int CW = $clog2(SKEW_MAX + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HUNT   = 2'd1,
        STREAM = 2'd2
    } state_t;

    state_t                  state;
    logic [NUM_CHANNELS-1:0] mask;
    logic [NUM_CHANNELS-1:0] armed;
    logic [CW-1:0]           skew_cnt;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0]             wr_ptr [NUM_CHANNELS];
    logic [AW:0]             rd_ptr [NUM_CHANNELS];
    logic [EW-1:0]           mem    [NUM_CHANNELS][FIFO_DEPTH];

    logic [EW-1:0]           head   [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0] fifo_empty;
    logic [NUM_CHANNELS-1:0] fifo_full;
    logic [NUM_CHANNELS-1:0] ls_in;
    logic [NUM_CHANNELS-1:0] arming;
    logic [NUM_CHANNELS-1:0] armed_next;
    logic [NUM_CHANNELS-1:0] wr_req;
    logic [NUM_CHANNELS-1:0] wr_en;
    logic [NUM_CHANNELS-1:0] pop_vec;
    logic [NUM_CHANNELS-1:0] ovf_hit;
    logic                    all_armed;
    logic                    heads_present;
    logic                    ls_agree;
    logic                    ref_ls;
    logic                    ref_fs;
    logic                    ref_found;
    logic                    word_ok;
    logic                    pop;
    logic                    misalign_hit;
    logic                    timeout_hit;
    logic                    flush;

    // ------------------------------------------------------------------
    // FIFO status, head decode and control decisions
    // ------------------------------------------------------------------
    always_comb begin
        fifo_empty = '0;
        fifo_full  = '0;
        for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
            head[ch]       = mem[ch][rd_ptr[ch][AW-1:0]];
            fifo_empty[ch] = (wr_ptr[ch] == rd_ptr[ch]);
            fifo_full[ch]  = (wr_ptr[ch][AW] != rd_ptr[ch][AW]) &&
                             (wr_ptr[ch][AW-1:0] == rd_ptr[ch][AW-1:0]);
        end

        // Merged flags come from the lowest-numbered enabled channel.
        ref_ls    = 1'b0;
        ref_fs    = 1'b0;
        ref_found = 1'b0;
        for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
            if (mask[ch] && !ref_found) begin
                ref_ls    = head[ch][PIXEL_WIDTH];
                ref_fs    = head[ch][PIXEL_WIDTH+1];
                ref_found = 1'b1;
            end
        end

        ls_agree = 1'b1;
        for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
            if (mask[ch] && (head[ch][PIXEL_WIDTH] != ref_ls)) begin
                ls_agree = 1'b0;
            end
        end

        heads_present = ((~fifo_empty & mask) == mask);
        word_ok       = (state == STREAM) && heads_present && ls_agree;
        misalign_hit  = (state == STREAM) && heads_present && !ls_agree;
        pop           = word_ok && out_ready;
        pop_vec       = mask & {NUM_CHANNELS{pop}};

        // frame_start implies line_start.
        ls_in = in_line_start | in_frame_start;

        arming = '0;
        wr_req = '0;
        if (state == HUNT) begin
            arming = mask & ~armed & in_valid & ls_in;
        end
        armed_next = armed | arming;
        if (state == HUNT) begin
            // Unarmed channels discard pixels until their line_start pixel.
            wr_req = mask & in_valid & armed_next;
        end else if (state == STREAM) begin
            wr_req = mask & in_valid;
        end

        // A pop in the same cycle frees the slot, so that is not an overflow.
        ovf_hit     = wr_req & fifo_full & ~pop_vec;
        all_armed   = ((armed_next & mask) == mask);
        timeout_hit = (state == HUNT) && !all_armed && (armed_next != '0) &&
                      (skew_cnt == CW'(SKEW_MAX));

        flush = resync || (ovf_hit != '0) || misalign_hit || timeout_hit;
        // The pixel presented during a flush cycle is discarded.
        wr_en = flush ? '0 : wr_req;
    end

    // ------------------------------------------------------------------
    // Merged output word
    // ------------------------------------------------------------------
    always_comb begin
        out_valid       = word_ok;
        out_line_start  = word_ok && ref_ls;
        out_frame_start = word_ok && ref_fs;
        out_data        = '0;
        for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
            if (word_ok && mask[ch]) begin
                out_data[ch*PIXEL_WIDTH +: PIXEL_WIDTH] = head[ch][PIXEL_WIDTH-1:0];
            end
        end
    end

    assign aligned = (state == STREAM);

    // ------------------------------------------------------------------
    // FIFO storage (data only, no reset)
    // ------------------------------------------------------------------
    always_ff @(posedge clk_sys) begin
        for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
            if (wr_en[ch]) begin
                mem[ch][wr_ptr[ch][AW-1:0]] <= {in_frame_start[ch], ls_in[ch],
                                                in_data[ch*PIXEL_WIDTH +: PIXEL_WIDTH]};
            end
        end
    end

    // ------------------------------------------------------------------
    // Control state: FSM, pointers, skew counter, sticky flags
    // ------------------------------------------------------------------
    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            mask           <= '0;
            armed          <= '0;
            skew_cnt       <= '0;
            skew_error     <= 1'b0;
            misalign_error <= 1'b0;
            overflow       <= '0;
            for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
                wr_ptr[ch] <= '0;
                rd_ptr[ch] <= '0;
            end
        end else begin
            // A new error in the same cycle as clear_errors wins.
            skew_error     <= (skew_error & ~clear_errors) | (timeout_hit & ~resync);
            misalign_error <= (misalign_error & ~clear_errors) | (misalign_hit & ~resync);
            overflow       <= (overflow & ~{NUM_CHANNELS{clear_errors}}) |
                              (resync ? '0 : ovf_hit);

            if (flush) begin
                for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
                    wr_ptr[ch] <= '0;
                    rd_ptr[ch] <= '0;
                end
                armed    <= '0;
                skew_cnt <= '0;
                state    <= resync ? IDLE : HUNT;
            end else begin
                for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
                    if (wr_en[ch]) begin
                        wr_ptr[ch] <= wr_ptr[ch] + 1'b1;
                    end
                    if (pop_vec[ch]) begin
                        rd_ptr[ch] <= rd_ptr[ch] + 1'b1;
                    end
                end

                case (state)
                    IDLE: begin
                        if (ch_enable != '0) begin
                            mask  <= ch_enable;
                            state <= HUNT;
                        end
                    end
                    HUNT: begin
                        armed <= armed_next;
                        if (all_armed) begin
                            state    <= STREAM;
                            skew_cnt <= '0;
                        end else if (armed_next != '0) begin
                            // Reads 0 on the cycle the first channel arms.
                            skew_cnt <= skew_cnt + CW'(1);
                        end
                    end
                    STREAM: begin
                        state <= STREAM;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_afe2256_channel_aligner.sv
module tb_afe2256_channel_aligner;

    localparam int NC = 4;
    localparam int PW = 12;
    localparam int FD = 16;
    localparam int SM = 8;
    localparam int WW = NC*PW + 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NC-1:0]     ch_enable;
    logic              resync;
    logic              clear_errors;
    logic [NC*PW-1:0]  in_data;
    logic [NC-1:0]     in_valid;
    logic [NC-1:0]     in_line_start;
    logic [NC-1:0]     in_frame_start;
    logic [NC*PW-1:0]  out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_line_start;
    logic              out_frame_start;
    logic              aligned;
    logic              skew_error;
    logic              misalign_error;
    logic [NC-1:0]     overflow;

    always #5 clk = ~clk;

    afe2256_channel_aligner #(
        .NUM_CHANNELS(NC),
        .PIXEL_WIDTH (PW),
        .FIFO_DEPTH  (FD),
        .SKEW_MAX    (SM)
    ) dut (
        .clk_sys        (clk),
        .rst            (rst),
        .ch_enable      (ch_enable),
        .resync         (resync),
        .clear_errors   (clear_errors),
        .in_data        (in_data),
        .in_valid       (in_valid),
        .in_line_start  (in_line_start),
        .in_frame_start (in_frame_start),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_line_start (out_line_start),
        .out_frame_start(out_frame_start),
        .aligned        (aligned),
        .skew_error     (skew_error),
        .misalign_error (misalign_error),
        .overflow       (overflow)
    );

    int              n_checks  = 0;
    int              n_fail    = 0;
    int              cyc_cnt   = 0;
    int              ls_cyc    = 0;
    int              first_vld = -1;
    bit              sb_on     = 1'b0;
    bit              chk_lanes = 1'b0;
    bit              seen_vld  = 1'b0;
    int              off [NC];
    logic [WW-1:0]   sb_q [$];

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Output monitor: latency capture, lane checks and scoreboard pops.
    initial begin : monitor
        logic [WW-1:0] e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (out_valid && !seen_vld) begin
                    seen_vld  = 1'b1;
                    first_vld = cyc_cnt;
                end
                if (chk_lanes) begin
                    check("lane0_zero", 64'(out_data[0 +: PW]), 64'd0);
                    check("lane2_zero", 64'(out_data[2*PW +: PW]), 64'd0);
                end
                if (sb_on && out_valid && out_ready) begin
                    check("sb_has_entry", 64'(sb_q.size() > 0), 64'd1);
                    if (sb_q.size() > 0) begin
                        e = sb_q.pop_front();
                        check("sb_word", 64'({out_frame_start, out_line_start, out_data}), 64'(e));
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drive one cycle of input; returns 1ns after the next rising edge.
    task automatic drive(input logic [NC-1:0] v, input logic [NC-1:0] ls,
                         input logic [NC-1:0] fs, input logic [NC*PW-1:0] d);
        in_valid       = v;
        in_line_start  = ls;
        in_frame_start = fs;
        in_data        = d;
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive('0, '0, '0, '0);
    endtask

    task automatic do_resync();
        resync = 1'b1;
        idle(1);
        resync = 1'b0;
        idle(1);
    endtask

    // Send one line on all lanes with per-lane start offsets off[].
    // Lane c pixel n = base + c*step + n. Expected merged words (all lanes
    // enabled) are queued on the cycle the last lane presents pixel n.
    task automatic send_line(input int npix, input bit fs_first, input int base, input int step);
        int maxoff;
        logic [NC-1:0]    v, ls, fs;
        logic [NC*PW-1:0] d, wd;
        maxoff = 0;
        for (int c = 0; c < NC; c++) if (off[c] > maxoff) maxoff = off[c];
        for (int t = 0; t < maxoff + npix; t++) begin
            int nl;
            v = '0; ls = '0; fs = '0; d = '0;
            for (int c = 0; c < NC; c++) begin
                int n;
                n = t - off[c];
                if (n >= 0 && n < npix) begin
                    v[c]  = 1'b1;
                    ls[c] = (n == 0);
                    fs[c] = (n == 0) && fs_first;
                    d[c*PW +: PW] = PW'(base + c*step + n);
                end
            end
            nl = t - maxoff;
            if (nl >= 0 && nl < npix) begin
                for (int c = 0; c < NC; c++) wd[c*PW +: PW] = PW'(base + c*step + nl);
                sb_q.push_back({(nl == 0) && fs_first, nl == 0, wd});
                if (nl == 0) ls_cyc = cyc_cnt;
            end
            drive(v, ls, fs, d);
        end
        in_valid = '0; in_line_start = '0; in_frame_start = '0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 40 && sb_q.size() != 0; i++) idle(1);
        check("sb_drained", 64'(sb_q.size()), 64'd0);
    endtask

    initial begin : stim
        logic [NC*PW-1:0] dw;
        rst = 1'b1; ch_enable = '0; resync = 1'b0; clear_errors = 1'b0;
        in_data = '0; in_valid = '0; in_line_start = '0; in_frame_start = '0;
        out_ready = 1'b0;
        for (int c = 0; c < NC; c++) off[c] = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_aligned", 64'(aligned), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_errors", 64'({skew_error, misalign_error, overflow}), 64'd0);
        rst = 1'b0;
        ch_enable = 4'hF;
        out_ready = 1'b1;
        idle(3);
        check("hunt_not_aligned", 64'(aligned), 64'd0);

        // Aligned start, 0x100+n in every lane, frame start on first word.
        seen_vld = 1'b0; sb_on = 1'b1;
        send_line(8, 1'b1, 'h100, 0);
        check("t1_latency", 64'(first_vld - ls_cyc), 64'd1);
        check("t1_aligned", 64'(aligned), 64'd1);
        wait_drain();

        // Skew within limit: ch3 five cycles behind.
        do_resync();
        check("t2_hunt", 64'(aligned), 64'd0);
        off[3] = 5;
        seen_vld = 1'b0;
        send_line(6, 1'b0, 'h100, 'h100);
        check("t2_latency", 64'(first_vld - ls_cyc), 64'd1);
        check("t2_aligned", 64'(aligned), 64'd1);
        check("t2_no_skew_err", 64'(skew_error), 64'd0);
        wait_drain();
        off[3] = 0;
        sb_on = 1'b0;

        // Skew timeout: ch2 never presents line_start.
        do_resync();
        drive(4'b1011, 4'b1011, '0, {12'h031, 12'h000, 12'h011, 12'h001});
        for (int k = 1; k <= SM; k++) begin
            check("t3_skew_early", 64'(skew_error), 64'd0);
            if (k == SM) clear_errors = 1'b1;
            idle(1);
            clear_errors = 1'b0;
        end
        check("t3_skew_set_over_clear", 64'(skew_error), 64'd1);
        check("t3_not_aligned", 64'(aligned), 64'd0);
        idle(1);
        check("t3_skew_sticky", 64'(skew_error), 64'd1);
        check("t3_out_valid", 64'(out_valid), 64'd0);
        clear_errors = 1'b1; idle(1); clear_errors = 1'b0;
        check("t3_skew_cleared", 64'(skew_error), 64'd0);

        // Backpressure overflow: 17 pixels into 16-deep FIFOs.
        do_resync();
        out_ready = 1'b0;
        for (int t = 0; t < FD; t++) drive('1, (t == 0) ? '1 : '0, '0, {NC{PW'('h100 + t)}});
        check("t4_full_valid", 64'(out_valid), 64'd1);
        check("t4_no_ovf_yet", 64'(overflow), 64'd0);
        drive('1, '0, '0, {NC{PW'('h110)}});
        check("t4_overflow", 64'(overflow), 64'hF);
        check("t4_hunt", 64'(aligned), 64'd0);
        check("t4_flushed", 64'(out_valid), 64'd0);
        clear_errors = 1'b1; idle(1); clear_errors = 1'b0;
        check("t4_ovf_cleared", 64'(overflow), 64'd0);
        // Pop and write on a full FIFO in the same cycle.
        for (int t = 0; t < FD; t++) drive('1, (t == 0) ? '1 : '0, '0, {NC{PW'('h200 + t)}});
        out_ready = 1'b1;
        drive('1, '0, '0, {NC{PW'('h210)}});
        out_ready = 1'b0;
        check("t4_popwrite_no_ovf", 64'(overflow), 64'd0);
        check("t4_popwrite_aligned", 64'(aligned), 64'd1);
        dw = {NC{12'h201}};
        check("t4_popwrite_head", 64'(out_data), 64'(dw));

        // Misalign with mask 1010: ch1 carries one extra pixel.
        ch_enable = 4'b1010;
        do_resync();
        out_ready = 1'b1; seen_vld = 1'b0; sb_on = 1'b1; chk_lanes = 1'b1;
        sb_q.push_back({2'b01, 12'h311, 12'h000, 12'h111, 12'h000});
        drive('1, '1, '0, {12'h311, 12'h555, 12'h111, 12'hAAA});
        sb_q.push_back({2'b00, 12'h312, 12'h000, 12'h112, 12'h000});
        drive('1, 4'b0101, '0, {12'h312, 12'h555, 12'h112, 12'hAAA});
        sb_q.push_back({2'b00, 12'h313, 12'h000, 12'h1FF, 12'h000});
        drive('1, 4'b0101, '0, {12'h313, 12'h555, 12'h1FF, 12'hAAA});
        sb_q.push_back({2'b00, 12'h314, 12'h000, 12'h113, 12'h000});
        drive('1, 4'b0101, '0, {12'h314, 12'h555, 12'h113, 12'hAAA});
        drive(4'b0111, 4'b0101, '0, {12'h000, 12'h555, 12'h114, 12'hAAA});
        drive('1, '1, '0, {12'h321, 12'h555, 12'h121, 12'hAAA});
        for (int i = 0; i < 10 && !misalign_error; i++) idle(1);
        check("t5_misalign", 64'(misalign_error), 64'd1);
        check("t5_hunt", 64'(aligned), 64'd0);
        check("t5_ovf0", 64'(overflow[0]), 64'd0);
        check("t5_ovf_all", 64'(overflow), 64'd0);
        check("t5_streamed", 64'(seen_vld), 64'd1);
        check("t5_sb_empty", 64'(sb_q.size()), 64'd0);
        sb_on = 1'b0; chk_lanes = 1'b0;

        // Reset mid-stream, then re-lock.
        ch_enable = 4'hF;
        do_resync();
        out_ready = 1'b0;
        drive('1, '1, '0, {NC{12'h0A0}});
        drive('1, '0, '0, {NC{12'h0A1}});
        check("t6_pre_valid", 64'(out_valid), 64'd1);
        check("t6_pre_misalign", 64'(misalign_error), 64'd1);
        #2 rst = 1'b1;
        #1;
        check("t6_rst_valid", 64'(out_valid), 64'd0);
        check("t6_rst_aligned", 64'(aligned), 64'd0);
        check("t6_rst_data", 64'(out_data), 64'd0);
        check("t6_rst_misalign", 64'(misalign_error), 64'd0);
        in_valid = '0; in_line_start = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("t6_idle", 64'(aligned), 64'd0);
        idle(1);
        out_ready = 1'b1; seen_vld = 1'b0; sb_on = 1'b1;
        send_line(6, 1'b1, 'h300, 'h10);
        check("t6_latency", 64'(first_vld - ls_cyc), 64'd1);
        check("t6_aligned", 64'(aligned), 64'd1);
        wait_drain();
        sb_on = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
